hs_rr_arbiter: RTL
==================

// Module: hs_rr_arbiter
// PURPOSE
//  Shares one downstream 4-phase req/ack channel (e.g. a ctrl_rst_on stage) among N_REQ upstream 4-phase requesters.
//  Clocked round-robin arbiter: relays one full 4-phase cycle of the granted requester, then rotates priority.
//  Drives one-hot grant[] so the datapath mux follows the winner; flags a stalled downstream ack with a sticky error.
// PARAMETERS
//  N_REQ     4    number of upstream requesters (2..16); IDX_W = $clog2(N_REQ) derived localparam
//  TIMEOUT   255  max cycles waiting for ack_out rise in FWD_REQ; 0 disables the watchdog
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  req_in     in   N_REQ  upstream 4-phase requests
//  ack_in     out  N_REQ  upstream 4-phase acknowledges, at most one bit high
//  req_out    out  1      downstream request
//  ack_out    in   1      downstream acknowledge
//  grant      out  N_REQ  one-hot owner of the channel, 0 when idle
//  grant_idx  out  IDX_W  binary index of grant, 0 when idle
//  busy       out  1      high in every state except IDLE
//  err_clr    in   1      clears err_timeout
//  err_timeout out 1      sticky, set when the watchdog expires
// BEHAVIOUR
//  - All outputs are registered. rst (sampled at edge) forces state=IDLE, ptr=0, cnt=0, and all outputs to 0. This holds mid-handshake as well.
//  - FSM IDLE -> FWD_REQ -> FWD_ACK -> RTZ_REQ -> RTZ_ACK -> IDLE. Below, r = sampled req_in and a = sampled ack_out.
//  - IDLE: if r != 0 and a == 0, pick the first set bit searching ptr, ptr+1, ... with wrap N_REQ-1 -> 0.
//      Register grant/grant_idx, set req_out=1, go to FWD_REQ. req_out rises 1 cycle after r is seen.
//      If a == 1 in IDLE, do not grant; wait.
//  - FWD_REQ: when a == 1, set ack_in[g]=1 and go to FWD_ACK. Otherwise cnt++.
//      If TIMEOUT != 0 and cnt reaches TIMEOUT: req_out=0, err_timeout=1, ack_in stays 0, go to RTZ_ACK.
//  - FWD_ACK: when r[g] == 0, set req_out=0 and go to RTZ_REQ.
//  - RTZ_REQ: when a == 0, set ack_in[g]=0 and go to RTZ_ACK.
//  - RTZ_ACK: one cycle, or longer until a == 0 after a timeout.
//      Then clear grant/grant_idx, set ptr = (g+1) mod N_REQ, cnt=0, go to IDLE.
//  - Minimum full cycle is 5 clocks plus environment delays. The next grant can issue the cycle after IDLE is re-entered.
//  - Requests arriving or dropping for non-granted bits never affect the current transaction.
//  - A new request from the same owner is arbitrated fresh, behind the others.
//  - A protocol violation (r[g] drops in FWD_REQ) is ignored: the FSM keeps waiting for a.
//  - Simultaneous err_clr and a timeout event: set wins. err_clr is otherwise a 1-cycle clear.
//  - grant is stable from the IDLE exit edge until the RTZ_ACK exit edge, and covers the whole downstream handshake.
// CONFIGURATION
//  HS_ARB_SYNC_EN defined:
//    - Each req_in bit and ack_out pass through a 2-flop synchronizer (reset to 0) before the FSM.
//    - Every reaction gains 2 cycles of latency, e.g. req_out rises 3 cycles after req_in.
//    - The watchdog counts the same cycles.
//  HS_ARB_SYNC_EN undefined:
//    - Inputs are sampled directly and must be synchronous to clk.
// TESTING
//  1 Reset: hold rst=1 mid-FWD_ACK with req_in=4'b0010
//    -> next edge req_out=0, ack_in=0, grant=0, busy=0, err_timeout=0.
//  2 Single requester: req_in=4'b0100, ack_out responds 2 cycles after req_out
//    -> grant=4'b0100, grant_idx=2, ack_in[2] follows the full 4-phase sequence, ptr=3 after.
//  3 Round robin: req_in=4'b1111 held, auto-acking downstream
//    -> grant order 0,1,2,3,0, with no two ack_in bits high at once.
//  4 Wrap: ptr=3, req_in=4'b1001 -> grant idx 3 first, then idx 0.
//  5 Timeout: TIMEOUT=8, req_in=4'b0001, ack_out held 0
//    -> req_out drops 8 cycles after rising, err_timeout=1, ack_in[0] never rises.
//    -> err_clr=1 then clears the flag.
//  6 HS_ARB_SYNC_EN build: repeat test 2 -> every edge delayed by exactly 2 extra cycles.

Source files
------------

// File: rtl/hs_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs_rr_arbiter
// Brief    : Round-robin arbiter that relays one full 4-phase req/ack cycle at
//            a time from N_REQ upstream requesters onto one downstream channel.
//            Defining HS_ARB_SYNC_EN adds 2-flop synchronizers on req_in/ack_out.
// Revision : 1.0 - initial release
// ============================================================================
module hs_rr_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 255,
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] ack_in,
    output logic             req_out,
    input  logic             ack_out,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    input  logic             err_clr,
    output logic             err_timeout
);

    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FWD_REQ = 3'd1,
        S_FWD_ACK = 3'd2,
        S_RTZ_REQ = 3'd3,
        S_RTZ_ACK = 3'd4
    } state_t;

    logic [N_REQ-1:0] w_req;
    logic             w_ack;

`ifdef HS_ARB_SYNC_EN
    logic [N_REQ-1:0] r_req_s1, r_req_s2;
    logic             r_ack_s1, r_ack_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_s1 <= '0;
            r_req_s2 <= '0;
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
        end else begin
            r_req_s1 <= req_in;
            r_req_s2 <= r_req_s1;
            r_ack_s1 <= ack_out;
            r_ack_s2 <= r_ack_s1;
        end
    end

    assign w_req = r_req_s2;
    assign w_ack = r_ack_s2;
`else
    assign w_req = req_in;
    assign w_ack = ack_out;
`endif

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_to, w_to_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0] r_grant_idx, w_grant_idx_nxt;
    logic             r_req_out, w_req_out_nxt;
    logic [N_REQ-1:0] r_ack_in, w_ack_in_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_err, w_err_nxt;
    logic             w_to_evt;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_vld;
    int               w_pos;

    // First requesting bit at or after the rotating pointer, wrapping around.
    always_comb begin
        w_pick_idx = '0;
        w_pick_vld = 1'b0;
        w_pos      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = (int'(r_ptr) + k) % N_REQ;
            if (!w_pick_vld && w_req[w_pos]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = IDX_W'(w_pos);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_to_nxt        = r_to;
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_req_out_nxt   = r_req_out;
        w_ack_in_nxt    = r_ack_in;
        w_to_evt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pick_vld && !w_ack) begin
                    w_grant_nxt     = N_REQ'(1) << w_pick_idx;
                    w_grant_idx_nxt = w_pick_idx;
                    w_req_out_nxt   = 1'b1;
                    w_state_nxt     = S_FWD_REQ;
                end
            end
            S_FWD_REQ: begin
                if (w_ack) begin
                    w_ack_in_nxt = r_grant;
                    w_state_nxt  = S_FWD_ACK;
                end else if (TIMEOUT != 0 && r_cnt == c_CNT_LAST) begin
                    w_req_out_nxt = 1'b0;
                    w_to_evt      = 1'b1;
                    w_to_nxt      = 1'b1;
                    w_state_nxt   = S_RTZ_ACK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_FWD_ACK: begin
                if ((w_req & r_grant) == '0) begin
                    w_req_out_nxt = 1'b0;
                    w_state_nxt   = S_RTZ_REQ;
                end
            end
            S_RTZ_REQ: begin
                if (!w_ack) begin
                    w_ack_in_nxt = '0;
                    w_state_nxt  = S_RTZ_ACK;
                end
            end
            S_RTZ_ACK: begin
                // After a watchdog abort the downstream may still be acking late.
                if (!r_to || !w_ack) begin
                    w_grant_nxt     = '0;
                    w_grant_idx_nxt = '0;
                    w_ptr_nxt       = (r_grant_idx == c_IDX_LAST) ? '0 : r_grant_idx + 1'b1;
                    w_cnt_nxt       = '0;
                    w_to_nxt        = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_err_nxt  = w_to_evt ? 1'b1 : (err_clr ? 1'b0 : r_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_to        <= 1'b0;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_req_out   <= 1'b0;
            r_ack_in    <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_to        <= w_to_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_req_out   <= w_req_out_nxt;
            r_ack_in    <= w_ack_in_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign ack_in      = r_ack_in;
    assign req_out     = r_req_out;
    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign busy        = r_busy;
    assign err_timeout = r_err;

endmodule
`default_nettype wire
